// File: rtl/touch_ui_pkg.sv
// Shared touch UI types and default panel geometry / timing constants.
// Used by the mode controller and the region decoder.
package touch_ui_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DECODE   = 2'd1,
        ST_HOLDOFF  = 2'd2,
        ST_WAIT_REL = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ACT_PREV   = 2'd0,
        ACT_NEXT   = 2'd1,
        ACT_TOGGLE = 2'd2
    } action_t;

    localparam logic [11:0] DEF_X_SPLIT     = 12'd2048;
    localparam logic [11:0] DEF_Y_TOP       = 12'd256;
    localparam logic [23:0] DEF_HOLDOFF_CNT = 24'd12_500_000;
    localparam logic [27:0] DEF_AUTO_CNT    = 28'd150_000_000;

endpackage

// File: rtl/touch_region_decoder.sv
// Maps a touch coordinate to a UI action; the top strip wins over
// the left/right split.
module touch_region_decoder
    import touch_ui_pkg::*;
#(
    parameter logic [11:0] X_SPLIT = DEF_X_SPLIT,
    parameter logic [11:0] Y_TOP   = DEF_Y_TOP
) (
    input  logic [11:0] xCoord,
    input  logic [11:0] yCoord,
    output action_t     action
);

    logic inTop;
    logic inLeft;

    assign inTop  = (yCoord < Y_TOP);
    assign inLeft = (xCoord < X_SPLIT);

    always_comb begin
        action = ACT_NEXT;
        unique case (1'b1)
            inTop:           action = ACT_TOGGLE;
            !inTop && inLeft: action = ACT_PREV;
            default:         action = ACT_NEXT;
        endcase
    end

endmodule

// File: rtl/touch_mode_controller.sv
// Turns touch panel presses into prev/next/slideshow actions with a
// one-press-one-action interlock and a slideshow auto-advance timer.
module touch_mode_controller
    import touch_ui_pkg::*;
#(
    parameter int          NUM_MODES   = 4,
    parameter int          MODE_W      = 2,
    parameter logic [11:0] X_SPLIT     = DEF_X_SPLIT,
    parameter logic [11:0] Y_TOP       = DEF_Y_TOP,
    parameter logic [23:0] HOLDOFF_CNT = DEF_HOLDOFF_CNT,
    parameter logic [27:0] AUTO_CNT    = DEF_AUTO_CNT
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iTOUCH_IRQ,
    input  logic [11:0]       iX_COORD,
    input  logic [11:0]       iY_COORD,
    input  logic              iNEW_COORD,
    output logic [MODE_W-1:0] oDISPLAY_MODE,
    output logic              oMODE_STB,
    output logic              oSLIDESHOW,
    output logic              oBUSY
);

    localparam logic [MODE_W-1:0] LAST = MODE_W'(NUM_MODES - 1);
    localparam logic [MODE_W-1:0] ONE  = MODE_W'(1);

    state_t      state;
    action_t     action;
    logic [23:0] holdCnt;
    logic [27:0] autoCnt;
    logic [11:0] xLat;
    logic [11:0] yLat;
    logic [MODE_W-1:0] modeInc;
    logic [MODE_W-1:0] modeDec;

    // Explicit wrap so non-power-of-two mode counts behave
    assign modeInc = (oDISPLAY_MODE == LAST) ? '0 : oDISPLAY_MODE + ONE;
    assign modeDec = (oDISPLAY_MODE == '0) ? LAST : oDISPLAY_MODE - ONE;

    touch_region_decoder #(
        .X_SPLIT(X_SPLIT),
        .Y_TOP  (Y_TOP)
    ) uDecoder (
        .xCoord(xLat),
        .yCoord(yLat),
        .action(action)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state         <= ST_IDLE;
            holdCnt       <= '0;
            autoCnt       <= '0;
            xLat          <= '0;
            yLat          <= '0;
            oDISPLAY_MODE <= '0;
            oMODE_STB     <= 1'b0;
            oSLIDESHOW    <= 1'b0;
            oBUSY         <= 1'b0;
        end else begin
            oMODE_STB <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    // A touch beats a coincident auto-advance
                    if (iNEW_COORD) begin
                        xLat    <= iX_COORD;
                        yLat    <= iY_COORD;
                        autoCnt <= '0;
                        state   <= ST_DECODE;
                        oBUSY   <= 1'b1;
                    end else if (oSLIDESHOW) begin
                        if (autoCnt == AUTO_CNT - 28'd1) begin
                            autoCnt       <= '0;
                            oDISPLAY_MODE <= modeInc;
                            oMODE_STB     <= 1'b1;
                        end else begin
                            autoCnt <= autoCnt + 28'd1;
                        end
                    end else begin
                        autoCnt <= '0;
                    end
                end
                ST_DECODE: begin
                    state   <= ST_HOLDOFF;
                    autoCnt <= '0;
                    unique case (action)
                        ACT_TOGGLE: oSLIDESHOW <= ~oSLIDESHOW;
                        ACT_PREV: begin
                            oDISPLAY_MODE <= modeDec;
                            oMODE_STB     <= 1'b1;
                        end
                        ACT_NEXT: begin
                            oDISPLAY_MODE <= modeInc;
                            oMODE_STB     <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_HOLDOFF: begin
                    if (holdCnt == HOLDOFF_CNT - 24'd1) begin
                        holdCnt <= '0;
                        state   <= ST_WAIT_REL;
                    end else begin
                        holdCnt <= holdCnt + 24'd1;
                    end
                end
                ST_WAIT_REL: begin
                    if (!iTOUCH_IRQ) begin
                        state <= ST_IDLE;
                        oBUSY <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    oBUSY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_touch_mode_controller.sv
// Randomised touch sequences against a transaction-timed reference model.
// Outputs are compared every cycle, 1 time unit after the rising edge.
module tb_touch_mode_controller;

    localparam int NM   = 3;
    localparam int HOLD = 8;
    localparam int AUTO = 20;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iTOUCH_IRQ;
    logic [11:0] iX_COORD;
    logic [11:0] iY_COORD;
    logic        iNEW_COORD;
    logic [1:0]  oDISPLAY_MODE;
    logic        oMODE_STB;
    logic        oSLIDESHOW;
    logic        oBUSY;

    int checks = 0;
    int errors = 0;

    // Reference model: expected outputs for the current cycle
    int          mMode;
    bit          mSlide;
    bit          mStb;
    bit          mBusy;
    int          age;
    int          run;
    logic [11:0] lx;
    logic [11:0] ly;

    touch_mode_controller #(
        .NUM_MODES  (NM),
        .MODE_W     (2),
        .X_SPLIT    (12'd2048),
        .Y_TOP      (12'd256),
        .HOLDOFF_CNT(24'd8),
        .AUTO_CNT   (28'd20)
    ) dut (
        .iCLK         (iCLK),
        .iRST         (iRST),
        .iTOUCH_IRQ   (iTOUCH_IRQ),
        .iX_COORD     (iX_COORD),
        .iY_COORD     (iY_COORD),
        .iNEW_COORD   (iNEW_COORD),
        .oDISPLAY_MODE(oDISPLAY_MODE),
        .oMODE_STB    (oMODE_STB),
        .oSLIDESHOW   (oSLIDESHOW),
        .oBUSY        (oBUSY)
    );

    always #5 iCLK = ~iCLK;

    task automatic checkVal(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mMode  = 0;
        mSlide = 0;
        mStb   = 0;
        mBusy  = 0;
        age    = 0;
        run    = 0;
        lx     = '0;
        ly     = '0;
    endtask

    task automatic applyAction();
        if (ly < 12'd256) begin
            mSlide = !mSlide;
        end else if (lx < 12'd2048) begin
            mMode = (mMode + NM - 1) % NM;
            mStb  = 1;
        end else begin
            mMode = (mMode + 1) % NM;
            mStb  = 1;
        end
    endtask

    // Advance the model over one clock edge using this cycle's inputs.
    // age counts cycles since the touch was accepted: 0 is the decode
    // cycle, 1..HOLD the lockout, beyond that waiting for release.
    task automatic modelStep();
        mStb = 0;
        if (iRST) begin
            modelReset();
            return;
        end
        if (!mBusy) begin
            if (iNEW_COORD) begin
                lx    = iX_COORD;
                ly    = iY_COORD;
                mBusy = 1;
                age   = 0;
                run   = 0;
            end else if (mSlide && run == AUTO - 1) begin
                mMode = (mMode + 1) % NM;
                mStb  = 1;
                run   = 0;
            end else begin
                run = mSlide ? run + 1 : 0;
            end
        end else begin
            if (age == 0) applyAction();
            else if (age > HOLD && !iTOUCH_IRQ) mBusy = 0;
            age++;
        end
    endtask

    task automatic checkOuts();
        checkVal("mode", 32'(oDISPLAY_MODE), 32'(mMode));
        checkVal("stb", 32'(oMODE_STB), 32'(mStb));
        checkVal("slideshow", 32'(oSLIDESHOW), 32'(mSlide));
        checkVal("busy", 32'(oBUSY), 32'(mBusy));
    endtask

    task automatic step();
        @(posedge iCLK);
        modelStep();
        #1;
        checkOuts();
    endtask

    task automatic idle(input int n);
        iNEW_COORD = 1'b0;
        iTOUCH_IRQ = 1'b0;
        repeat (n) step();
    endtask

    task automatic startTouch(input logic [11:0] x, input logic [11:0] y);
        iX_COORD   = x;
        iY_COORD   = y;
        iNEW_COORD = 1'b1;
        iTOUCH_IRQ = 1'b1;
        step();
        iNEW_COORD = 1'b0;
    endtask

    task automatic finishTouch(input int hold, input bit junk);
        int n = 0;
        while (mBusy && n < 300) begin
            if (n >= hold) iTOUCH_IRQ = 1'b0;
            if (junk && $urandom_range(0, 3) == 0) begin
                iNEW_COORD = 1'b1;
                iX_COORD   = 12'($urandom_range(0, 4095));
                iY_COORD   = 12'($urandom_range(0, 4095));
            end
            step();
            iNEW_COORD = 1'b0;
            n++;
        end
        iTOUCH_IRQ = 1'b0;
        checkVal("busy_timeout", 32'(mBusy), 32'd0);
    endtask

    task automatic touch(input logic [11:0] x, input logic [11:0] y,
                         input int hold, input bit junk);
        startTouch(x, y);
        finishTouch(hold, junk);
    endtask

    task automatic randTouch();
        logic [11:0] x;
        logic [11:0] y;
        x = 12'($urandom_range(0, 4095));
        y = 12'($urandom_range(256, 4095));
        case ($urandom_range(0, 5))
            0: y = 12'($urandom_range(0, 255));
            1: y = 12'd256;
            2: x = 12'd2048;
            3: x = 12'd2047;
            4: y = 12'd255;
            default: ;
        endcase
        touch(x, y, $urandom_range(0, 20), 1'($urandom_range(0, 1)));
    endtask

    task automatic collide();
        int n = 0;
        while (run != AUTO - 1 && n < 100) begin
            idle(1);
            n++;
        end
        checkVal("collide_timeout", 32'(run), 32'(AUTO - 1));
        touch(12'd100, 12'd1000, $urandom_range(0, 12), 1'b0);
    endtask

    initial begin
        modelReset();
        iRST       = 1'b1;
        iTOUCH_IRQ = 1'b0;
        iNEW_COORD = 1'b0;
        iX_COORD   = '0;
        iY_COORD   = '0;
        repeat (2) @(posedge iCLK);
        #1;
        checkOuts();
        iRST = 1'b0;
        idle(3);

        // Next / prev with wrap and the region boundaries
        touch(12'd3000, 12'd1000, 15, 1'b0);
        touch(12'd2048, 12'd1000, 4, 1'b1);
        touch(12'd4095, 12'd256, 0, 1'b0);
        touch(12'd100, 12'd1000, 12, 1'b1);
        touch(12'd2047, 12'd300, 20, 1'b1);
        touch(12'd3000, 12'd1000, 9, 1'b0);
        idle(5);

        // Slideshow on, auto advances, then off
        touch(12'd500, 12'd10, 10, 1'b0);
        idle(70);
        touch(12'd3000, 12'd10, 2, 1'b1);
        idle(50);

        // Touch colliding with the auto-advance terminal count
        touch(12'd4000, 12'd0, 5, 1'b0);
        collide();
        idle(45);

        // Reset in lockout with mode 2 and slideshow running
        for (int i = 0; i < 4; i++) begin
            startTouch(12'd3000, 12'd1000);
            step();
            if (mMode == 2) break;
            finishTouch(0, 1'b0);
        end
        checkVal("pre_rst_slide", 32'(oSLIDESHOW), 32'd1);
        #3;
        iRST = 1'b1;
        #1;
        checkVal("rst_mode", 32'(oDISPLAY_MODE), 32'd0);
        checkVal("rst_stb", 32'(oMODE_STB), 32'd0);
        checkVal("rst_slide", 32'(oSLIDESHOW), 32'd0);
        checkVal("rst_busy", 32'(oBUSY), 32'd0);
        modelReset();
        iTOUCH_IRQ = 1'b0;
        step();
        iRST = 1'b0;
        idle(2);
        touch(12'd3000, 12'd1000, 6, 1'b0);

        // Randomised traffic
        for (int i = 0; i < 40; i++) begin
            idle($urandom_range(0, 45));
            if (mSlide && $urandom_range(0, 2) == 0) collide();
            else randTouch();
        end
        idle(30);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
